snoopy_bus_arbiter: RTL and testbench



---
 rtl/snoopy_bus_arbiter_pkg.sv | 38 +++
 rtl/snoopy_bus_arbiter_if.sv | 57 +++++
 rtl/snoopy_bus_arbiter_round_robin_picker.sv | 55 +++++
 rtl/snoopy_bus_arbiter.sv | 166 ++++++++++++++++
 tb/tb_snoopy_bus_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snoopy_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : commands (package)
//  Description : Shared definitions for the snoopy command bus. Holds the
//                bus Command encoding, its width and the arbiter state type.
//  Contents    : Command  - NONE / BUS_READ / BUS_READ_EXCLUSIVE /
//                           BUS_INVALIDATE
//                COMMAND_WIDTH - bit width of one Command
//                state_t  - IDLE / SNOOP / DONE
//                cache_index_width() - owner index width for a cache count
//  Revision    : 1.0 - initial release
// ============================================================================
package commands;

    localparam int COMMAND_WIDTH = 2;

    // NONE must stay at zero: an all-zero slice means "no request".
    typedef enum logic [COMMAND_WIDTH-1:0] {
        NONE               = 2'd0,
        BUS_READ           = 2'd1,
        BUS_READ_EXCLUSIVE = 2'd2,
        BUS_INVALIDATE     = 2'd3
    } Command;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index width for a given number of caches; never narrower than one bit
    // so a single-cache build still has a legal owner field.
    function automatic int cache_index_width(input int num_caches);
        return (num_caches > 1) ? $clog2(num_caches) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoopy_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : snoopy_bus_arbiter_if
//  Description : Bundle of the snoopy command bus between the arbiter and
//                the cache controllers.
//  Signals     : snoopyCommandOut - per-cache requested command (cache->arb)
//                snoopAck         - per-cache snoop-done acknowledge
//                snoopyCommandIn  - broadcast command (arb->caches)
//                cacheNumberOut   - index of the current bus owner
//                snoopValid       - per-cache "snoop this command" strobe
//                grant            - one-hot owner indication
//                isInvalidated    - one-cycle completion pulse to the owner
//                busy             - arbiter is not idle
//  Modports    : master - arbiter side, slave - cache side
//  Revision    : 1.0 - initial release
// ============================================================================
interface snoopy_bus_arbiter_if
    import commands::*;
#(
    parameter int NUMBER_OF_CACHES   = 4,
    parameter int CACHE_NUMBER_WIDTH = cache_index_width(NUMBER_OF_CACHES),
    parameter int COMMAND_WIDTH      = commands::COMMAND_WIDTH
);

    logic [NUMBER_OF_CACHES*COMMAND_WIDTH-1:0] snoopyCommandOut;
    logic [NUMBER_OF_CACHES-1:0]               snoopAck;
    logic [COMMAND_WIDTH-1:0]                  snoopyCommandIn;
    logic [CACHE_NUMBER_WIDTH-1:0]             cacheNumberOut;
    logic [NUMBER_OF_CACHES-1:0]               snoopValid;
    logic [NUMBER_OF_CACHES-1:0]               grant;
    logic [NUMBER_OF_CACHES-1:0]               isInvalidated;
    logic                                      busy;

    modport master (
        input  snoopyCommandOut,
        input  snoopAck,
        output snoopyCommandIn,
        output cacheNumberOut,
        output snoopValid,
        output grant,
        output isInvalidated,
        output busy
    );

    modport slave (
        output snoopyCommandOut,
        output snoopAck,
        input  snoopyCommandIn,
        input  cacheNumberOut,
        input  snoopValid,
        input  grant,
        input  isInvalidated,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/snoopy_bus_arbiter_round_robin_picker.sv
`default_nettype none
// ============================================================================
//  Module      : round_robin_picker
//  Description : Combinational round-robin selector. Searches the request
//                vector starting just above lastOwner and wrapping around;
//                the first requester found wins.
//  Ports       : request_i    - one bit per requester
//                lastOwner_i  - index of the most recent winner
//                winner_o     - index of the selected requester
//                anyRequest_o - at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module round_robin_picker #(
    parameter int NUM_REQUESTERS = 4,
    parameter int INDEX_WIDTH    = 2
) (
    input  wire logic [NUM_REQUESTERS-1:0] request_i,
    input  wire logic [INDEX_WIDTH-1:0]    lastOwner_i,
    output logic      [INDEX_WIDTH-1:0]    winner_o,
    output logic                           anyRequest_o
);

    logic                   w_foundHigh;
    logic                   w_foundLow;
    logic [INDEX_WIDTH-1:0] w_highIndex;
    logic [INDEX_WIDTH-1:0] w_lowIndex;

    // Wrap-around search done as two ascending scans folded into one loop:
    // the lowest requester above lastOwner has priority, otherwise the lowest
    // requester at or below it (which includes lastOwner itself, last).
    always_comb begin
        w_foundHigh = 1'b0;
        w_foundLow  = 1'b0;
        w_highIndex = '0;
        w_lowIndex  = '0;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (request_i[i]) begin
                if (INDEX_WIDTH'(i) > lastOwner_i) begin
                    if (!w_foundHigh) begin
                        w_highIndex = INDEX_WIDTH'(i);
                        w_foundHigh = 1'b1;
                    end
                end else if (!w_foundLow) begin
                    w_lowIndex = INDEX_WIDTH'(i);
                    w_foundLow = 1'b1;
                end
            end
        end
    end

    assign anyRequest_o = w_foundHigh | w_foundLow;
    assign winner_o     = w_foundHigh ? w_highIndex : w_lowIndex;

endmodule
`default_nettype wire

// File: rtl/snoopy_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : snoopy_bus_arbiter
//  Description : Round-robin sequencer for the shared snoopy command bus.
//                Grants one cache at a time, broadcasts its latched command
//                to every other cache, collects one acknowledge per snooper
//                and pulses isInvalidated back to the owner on completion.
//  Ports       : clock - system clock, rising edge
//                reset - synchronous, active-high
//                bus   - snoopy_bus_arbiter_if.master (see interface header)
//  Revision    : 1.0 - initial release
// ============================================================================
module snoopy_bus_arbiter
    import commands::*;
#(
    parameter int NUMBER_OF_CACHES   = 4,
    parameter int CACHE_NUMBER_WIDTH = cache_index_width(NUMBER_OF_CACHES),
    parameter int COMMAND_WIDTH      = commands::COMMAND_WIDTH
) (
    input wire logic             clock,
    input wire logic             reset,
    snoopy_bus_arbiter_if.master bus
);

    localparam int                       N                = NUMBER_OF_CACHES;
    localparam int                       W                = CACHE_NUMBER_WIDTH;
    localparam logic [COMMAND_WIDTH-1:0] CMD_NONE         = COMMAND_WIDTH'(NONE);
    // Starting with the last index makes cache 0 the first one searched.
    localparam logic [W-1:0]             LAST_OWNER_RESET = W'(N - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_q,     state_d;
    logic [W-1:0]             owner_q,     owner_d;
    logic [W-1:0]             lastOwner_q, lastOwner_d;
    logic [COMMAND_WIDTH-1:0] command_q,   command_d;
    logic [N-1:0]             ackMask_q,   ackMask_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [COMMAND_WIDTH-1:0] w_reqCommand [N];
    logic [N-1:0]             w_request;
    logic [N-1:0]             w_ownerOneHot;
    logic [W-1:0]             w_winner;
    logic                     w_anyRequest;
    logic [COMMAND_WIDTH-1:0] w_winnerCommand;
    logic [N-1:0]             w_acceptedAcks;

    logic [COMMAND_WIDTH-1:0] w_snoopyCommandIn;
    logic [N-1:0]             w_snoopValid;
    logic [N-1:0]             w_grant;
    logic [N-1:0]             w_isInvalidated;

    generate
        for (genvar i = 0; i < N; i++) begin : g_cache
            assign w_reqCommand[i]  = bus.snoopyCommandOut[i*COMMAND_WIDTH +: COMMAND_WIDTH];
            assign w_request[i]     = (w_reqCommand[i] != CMD_NONE);
            assign w_ownerOneHot[i] = (owner_q == W'(i));
        end
    endgenerate

    round_robin_picker #(
        .NUM_REQUESTERS (N),
        .INDEX_WIDTH    (W)
    ) u_picker (
        .request_i    (w_request),
        .lastOwner_i  (lastOwner_q),
        .winner_o     (w_winner),
        .anyRequest_o (w_anyRequest)
    );

    // Mux the winning slice without a variable array index, so the select
    // stays well-formed for cache counts that are not a power of two.
    always_comb begin
        w_winnerCommand = CMD_NONE;
        for (int i = 0; i < N; i++) begin
            if (w_winner == W'(i)) begin
                w_winnerCommand = w_reqCommand[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= LAST_OWNER_RESET;
            command_q   <= CMD_NONE;
            ackMask_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            command_q   <= command_d;
            ackMask_q   <= ackMask_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        lastOwner_d       = lastOwner_q;
        command_d         = command_q;
        ackMask_d         = ackMask_q;
        w_snoopyCommandIn = CMD_NONE;
        w_snoopValid      = '0;
        w_grant           = '0;
        w_isInvalidated   = '0;
        w_acceptedAcks    = '0;

        unique case (state_q)
            IDLE: begin
                // Owner and command are frozen here; later changes to the
                // owner's slice have no effect until the bus is idle again.
                if (w_anyRequest) begin
                    owner_d   = w_winner;
                    command_d = w_winnerCommand;
                    ackMask_d = '0;
                    state_d   = SNOOP;
                end
            end

            SNOOP: begin
                w_grant           = w_ownerOneHot;
                w_snoopyCommandIn = command_q;
                // Only caches still owing an ack are strobed; acks from the
                // owner or from caches already counted are masked off here.
                w_snoopValid      = ~w_ownerOneHot & ~ackMask_q;
                w_acceptedAcks    = w_snoopValid & bus.snoopAck;
                ackMask_d         = ackMask_q | w_acceptedAcks;
                if ((ackMask_q | w_acceptedAcks | w_ownerOneHot) == {N{1'b1}}) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                w_grant           = w_ownerOneHot;
                w_isInvalidated   = w_ownerOneHot;
                w_snoopyCommandIn = command_q;
                lastOwner_d       = owner_q;
                state_d           = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.snoopyCommandIn = w_snoopyCommandIn;
    assign bus.cacheNumberOut  = owner_q;
    assign bus.snoopValid      = w_snoopValid;
    assign bus.grant           = w_grant;
    assign bus.isInvalidated   = w_isInvalidated;
    assign bus.busy            = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snoopy_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snoopy_bus_arbiter
//  Description : Self-checking bench for snoopy_bus_arbiter. A four-cache
//                and a single-cache instance share clock and reset.
//                Expected owners are queued when requests are driven and
//                popped when isInvalidated pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snoopy_bus_arbiter;
    import commands::*;

    logic clock;
    logic reset;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    snoopy_bus_arbiter_if #(.NUMBER_OF_CACHES(4)) bus4 ();
    snoopy_bus_arbiter_if #(.NUMBER_OF_CACHES(1)) bus1 ();

    snoopy_bus_arbiter #(.NUMBER_OF_CACHES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus4.master)
    );

    snoopy_bus_arbiter #(.NUMBER_OF_CACHES(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input int idx, input Command cmd);
        bus4.snoopyCommandOut[idx*2 +: 2] = cmd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus4.snoopyCommandOut = '0;
        bus4.snoopAck = '0;
        bus1.snoopyCommandOut = '0;
        bus1.snoopAck = '0;
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus4.grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", bus4.grant); end
        checks++; if (bus4.isInvalidated !== 4'b0000) begin errors++; $display("FAIL reset_isInv got=%b exp=0000", bus4.isInvalidated); end
        checks++; if (bus4.snoopValid !== 4'b0000) begin errors++; $display("FAIL reset_snoopValid got=%b exp=0000", bus4.snoopValid); end
        checks++; if (bus4.snoopyCommandIn !== NONE) begin errors++; $display("FAIL reset_cmdIn got=%0d exp=0", bus4.snoopyCommandIn); end
        checks++; if (bus4.cacheNumberOut !== 2'd0) begin errors++; $display("FAIL reset_cacheNum got=%0d exp=0", bus4.cacheNumberOut); end
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus4.busy); end
    endtask

    task automatic test_single();
        int exp_owner;
        set_cmd(2, BUS_INVALIDATE);                 // cycle 0
        exp_q.push_back(2);
        tick();                                     // cycle 1
        checks++; if (bus4.grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b exp=0100", bus4.grant); end
        checks++; if (bus4.cacheNumberOut !== 2'd2) begin errors++; $display("FAIL single_cacheNum got=%0d exp=2", bus4.cacheNumberOut); end
        checks++; if (bus4.snoopValid !== 4'b1011) begin errors++; $display("FAIL single_snoopValid got=%b exp=1011", bus4.snoopValid); end
        checks++; if (bus4.snoopyCommandIn !== BUS_INVALIDATE) begin errors++; $display("FAIL single_cmdIn got=%0d exp=3", bus4.snoopyCommandIn); end
        checks++; if (bus4.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", bus4.busy); end
        bus4.snoopAck = 4'b1011;
        set_cmd(2, NONE);
        tick();                                     // cycle 2
        bus4.snoopAck = 4'b0000;
        exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if (exp_owner < 0 || bus4.isInvalidated !== (4'b0001 << exp_owner)) begin errors++; $display("FAIL single_isInv got=%b exp_owner=%0d", bus4.isInvalidated, exp_owner); end
        checks++; if (bus4.snoopValid !== 4'b0000) begin errors++; $display("FAIL single_done_snoopValid got=%b exp=0000", bus4.snoopValid); end
        checks++; if (bus4.grant !== 4'b0100) begin errors++; $display("FAIL single_done_grant got=%b exp=0100", bus4.grant); end
        tick();                                     // cycle 3
        checks++; if (bus4.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", bus4.busy); end
        checks++; if (bus4.isInvalidated !== 4'b0000) begin errors++; $display("FAIL single_idle_isInv got=%b exp=0000", bus4.isInvalidated); end
        checks++; if (bus4.snoopyCommandIn !== NONE) begin errors++; $display("FAIL single_idle_cmdIn got=%0d exp=0", bus4.snoopyCommandIn); end
        checks++; if (bus4.cacheNumberOut !== 2'd2) begin errors++; $display("FAIL single_idle_cacheNum got=%0d exp=2", bus4.cacheNumberOut); end
    endtask

    task automatic test_contention();
        int seen = 0;
        int owner;
        int last_done = -10;
        int cyc_count = 0;
        do_reset();
        foreach (exp_q[i]) exp_q[i] = 0;
        exp_q = '{0, 1, 3, 0, 1, 3};
        set_cmd(0, BUS_READ);
        set_cmd(1, BUS_READ);
        set_cmd(3, BUS_READ);
        for (int cyc = 0; cyc < 60 && seen < 6; cyc++) begin
            tick();
            cyc_count++;
            bus4.snoopAck = bus4.snoopValid;
            if (bus4.isInvalidated !== 4'b0000) begin
                owner = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                checks++;
                if (owner < 0 || bus4.isInvalidated !== (4'b0001 << owner)) begin
                    errors++;
                    $display("FAIL contention_owner got=%b exp_owner=%0d", bus4.isInvalidated, owner);
                end
                if (seen > 0) begin
                    checks++;
                    if (cyc_count - last_done != 3) begin
                        errors++;
                        $display("FAIL contention_spacing got=%0d exp=3", cyc_count - last_done);
                    end
                end
                last_done = cyc_count;
                seen++;
                if (seen == 6) bus4.snoopyCommandOut = '0;
            end
        end
        checks++;
        if (seen != 6) begin errors++; $display("FAIL contention_timeout got=%0d exp=6 completions", seen); end
        bus4.snoopAck = '0;
        bus4.snoopyCommandOut = '0;
        tick();
    endtask

    task automatic test_staggered();
        logic [3:0] sv_exp [6] = '{4'b1110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100};
        logic [3:0] ack_tbl [6] = '{4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0100};
        int exp_owner;
        set_cmd(0, BUS_READ_EXCLUSIVE);             // lastOwner=3, cache 0 next
        exp_q.push_back(0);
        for (int c = 0; c < 6; c++) begin
            tick();                                 // cycles 1..6
            if (c == 0) set_cmd(0, NONE);
            checks++;
            if (bus4.snoopValid !== sv_exp[c] || bus4.isInvalidated !== 4'b0000) begin
                errors++;
                $display("FAIL staggered_c%0d snoopValid=%b isInv=%b exp=%b/0000", c + 1, bus4.snoopValid, bus4.isInvalidated, sv_exp[c]);
            end
            bus4.snoopAck = ack_tbl[c];
        end
        tick();                                     // cycle 7
        bus4.snoopAck = '0;
        exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if (exp_owner < 0 || bus4.isInvalidated !== (4'b0001 << exp_owner)) begin errors++; $display("FAIL staggered_isInv got=%b exp_owner=%0d", bus4.isInvalidated, exp_owner); end
        checks++; if (bus4.snoopValid !== 4'b0000) begin errors++; $display("FAIL staggered_done_sv got=%b exp=0000", bus4.snoopValid); end
        tick();                                     // cycle 8
        checks++; if (bus4.isInvalidated !== 4'b0000 || bus4.busy !== 1'b0) begin errors++; $display("FAIL staggered_idle isInv=%b busy=%b exp=0000/0", bus4.isInvalidated, bus4.busy); end
    endtask

    task automatic test_spurious();
        int exp_owner;
        set_cmd(1, BUS_READ);                       // lastOwner=0, cache 1 next
        exp_q.push_back(1);
        tick();                                     // cycle 1
        checks++; if (bus4.snoopValid !== 4'b1101) begin errors++; $display("FAIL spurious_sv1 got=%b exp=1101", bus4.snoopValid); end
        bus4.snoopAck = 4'b0011;                    // owner ack is ignored
        tick();                                     // cycle 2
        checks++; if (bus4.snoopValid !== 4'b1100 || bus4.isInvalidated !== 4'b0000) begin errors++; $display("FAIL spurious_sv2 sv=%b isInv=%b exp=1100/0000", bus4.snoopValid, bus4.isInvalidated); end
        bus4.snoopAck = 4'b0011;                    // owner again + re-ack from cache 0
        set_cmd(1, BUS_INVALIDATE);
        tick();                                     // cycle 3
        checks++; if (bus4.snoopValid !== 4'b1100 || bus4.busy !== 1'b1 || bus4.isInvalidated !== 4'b0000) begin errors++; $display("FAIL spurious_sv3 sv=%b busy=%b isInv=%b exp=1100/1/0000", bus4.snoopValid, bus4.busy, bus4.isInvalidated); end
        checks++; if (bus4.snoopyCommandIn !== BUS_READ) begin errors++; $display("FAIL spurious_cmd_held got=%0d exp=1", bus4.snoopyCommandIn); end
        bus4.snoopAck = 4'b1100;
        set_cmd(1, NONE);
        tick();                                     // cycle 4
        bus4.snoopAck = '0;
        exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if (exp_owner < 0 || bus4.isInvalidated !== (4'b0001 << exp_owner)) begin errors++; $display("FAIL spurious_isInv got=%b exp_owner=%0d", bus4.isInvalidated, exp_owner); end
        checks++; if (bus4.snoopyCommandIn !== BUS_READ) begin errors++; $display("FAIL spurious_done_cmd got=%0d exp=1", bus4.snoopyCommandIn); end
        tick();                                     // cycle 5
        checks++; if (bus4.isInvalidated !== 4'b0000 || bus4.busy !== 1'b0) begin errors++; $display("FAIL spurious_extra_pulse isInv=%b busy=%b exp=0000/0", bus4.isInvalidated, bus4.busy); end
    endtask

    task automatic test_reset_mid();
        int exp_owner;
        set_cmd(2, BUS_READ);                       // lastOwner=1, cache 2 next
        exp_q.push_back(2);
        tick();                                     // cycle 1
        checks++; if (bus4.snoopValid !== 4'b1011) begin errors++; $display("FAIL resetmid_sv1 got=%b exp=1011", bus4.snoopValid); end
        bus4.snoopAck = 4'b0011;
        set_cmd(2, NONE);
        tick();                                     // cycle 2
        checks++; if (bus4.snoopValid !== 4'b1000) begin errors++; $display("FAIL resetmid_sv2 got=%b exp=1000", bus4.snoopValid); end
        bus4.snoopAck = '0;
        reset = 1'b1;
        exp_q.delete();                             // aborted transaction never completes
        tick();                                     // cycle 3
        reset = 1'b0;
        checks++;
        if (bus4.grant !== 4'b0000 || bus4.isInvalidated !== 4'b0000 || bus4.snoopValid !== 4'b0000 ||
            bus4.busy !== 1'b0 || bus4.cacheNumberOut !== 2'd0 || bus4.snoopyCommandIn !== NONE) begin
            errors++;
            $display("FAIL resetmid_outputs grant=%b isInv=%b sv=%b busy=%b num=%0d cmd=%0d exp all 0",
                     bus4.grant, bus4.isInvalidated, bus4.snoopValid, bus4.busy, bus4.cacheNumberOut, bus4.snoopyCommandIn);
        end
        set_cmd(0, BUS_READ);
        set_cmd(3, BUS_READ);
        exp_q.push_back(0);
        tick();                                     // cycle 4
        checks++; if (bus4.grant !== 4'b0001) begin errors++; $display("FAIL resetmid_priority got=%b exp=0001", bus4.grant); end
        checks++; if (bus4.isInvalidated !== 4'b0000) begin errors++; $display("FAIL resetmid_no_pulse got=%b exp=0000", bus4.isInvalidated); end
        bus4.snoopAck = 4'b1110;
        bus4.snoopyCommandOut = '0;
        tick();                                     // cycle 5
        bus4.snoopAck = '0;
        exp_owner = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        checks++; if (exp_owner < 0 || bus4.isInvalidated !== (4'b0001 << exp_owner)) begin errors++; $display("FAIL resetmid_isInv got=%b exp_owner=%0d", bus4.isInvalidated, exp_owner); end
        tick();
    endtask

    task automatic test_single_cache();
        bus1.snoopyCommandOut = BUS_READ;           // cycle 0
        tick();                                     // cycle 1
        checks++;
        if (bus1.grant !== 1'b1 || bus1.snoopValid !== 1'b0 || bus1.busy !== 1'b1 ||
            bus1.isInvalidated !== 1'b0 || bus1.snoopyCommandIn !== BUS_READ) begin
            errors++;
            $display("FAIL one_cache_snoop grant=%b sv=%b busy=%b isInv=%b cmd=%0d exp 1/0/1/0/1",
                     bus1.grant, bus1.snoopValid, bus1.busy, bus1.isInvalidated, bus1.snoopyCommandIn);
        end
        bus1.snoopyCommandOut = NONE;
        tick();                                     // cycle 2
        checks++; if (bus1.isInvalidated !== 1'b1) begin errors++; $display("FAIL one_cache_isInv got=%b exp=1", bus1.isInvalidated); end
        tick();                                     // cycle 3
        checks++; if (bus1.busy !== 1'b0 || bus1.isInvalidated !== 1'b0) begin errors++; $display("FAIL one_cache_idle busy=%b isInv=%b exp=0/0", bus1.busy, bus1.isInvalidated); end
    endtask

    initial begin
        reset = 1'b1;
        bus4.snoopyCommandOut = '0;
        bus4.snoopAck = '0;
        bus1.snoopyCommandOut = '0;
        bus1.snoopAck = '0;
        test_reset();
        test_single();
        test_contention();
        test_staggered();
        test_spurious();
        test_reset_mid();
        test_single_cache();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
